// File: rtl/face_sequencer.sv
// face_sequencer
// Chooses which of the four VGA faces the display core shows. There are three
// sources, in priority order: the manual switch override, face-change events
// from the audio classifier (valid/ready handshake), and an autonomous idle
// blink. A new face is only ever loaded on a vertical-sync falling edge, so a
// frame never shows a torn face.
//
// Ports:
//   clk          system clock (50 MHz)
//   reset        synchronous, active-high reset
//   vga_vs       active-low VGA vertical sync, asynchronous to clk
//   manual_en    manual override enable (level)
//   manual_face  face requested by the switches
//   evt_valid    event request valid
//   evt_face     requested event face
//   evt_ready    event accepted when evt_valid && evt_ready
//   face_select  registered face code: 0 neutral, 1 happy, 2 scared, 3 blink
//   face_update  one-cycle pulse in the first cycle face_select holds a new value
//   busy         high while an event is pending or being held
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | neutral face shown, counting frames towards the next blink
// S_BLINK   | blink face shown for BLINK_FRAMES frames
// S_PENDING | event accepted, waiting for the next frame to show it
// S_HOLD    | event face shown, counting down HOLD_FRAMES frames
// S_MANUAL  | switches own the face; returns to neutral a frame after release
module face_sequencer #(
    parameter int HOLD_FRAMES  = 30,
    parameter int BLINK_PERIOD = 180,
    parameter int BLINK_FRAMES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_vs,
    input  logic       manual_en,
    input  logic [1:0] manual_face,
    input  logic       evt_valid,
    input  logic [1:0] evt_face,
    output logic       evt_ready,
    output logic [1:0] face_select,
    output logic       face_update,
    output logic       busy
);
    localparam int PW = $clog2(BLINK_PERIOD) + 1;
    localparam int FW = $clog2(BLINK_FRAMES) + 1;
    localparam int HW = $clog2(HOLD_FRAMES) + 1;

    localparam logic [PW-1:0] PERIOD_LAST = PW'(BLINK_PERIOD - 1);
    localparam logic [FW-1:0] BLINK_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_FRAMES - 1);

    localparam logic [1:0] FACE_NEUTRAL = 2'd0;
    localparam logic [1:0] FACE_BLINK   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLINK,
        S_PENDING,
        S_HOLD,
        S_MANUAL
    } state_t;

    state_t        state, state_next;
    logic [1:0]    face_next;
    logic [1:0]    pend_face, pend_next;
    logic [PW-1:0] blink_cnt, blink_cnt_next;
    logic [FW-1:0] blk_cnt, blk_cnt_next;
    logic [HW-1:0] hold_cnt, hold_cnt_next;

    logic vs_s1, vs_s2, vs_s3;
    logic frame_tick;
    logic accept;

    // The delay flop sits behind the synchronizer so the tick is a clean
    // one-cycle pulse per falling edge of vsync.
    assign frame_tick = vs_s3 & ~vs_s2;

    assign evt_ready = ~reset & ~manual_en & (state != S_PENDING);
    assign busy      = (state == S_PENDING) || (state == S_HOLD);
    assign accept    = evt_valid & evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronizer resets high so leaving reset cannot look like a
            // falling edge.
            vs_s1       <= 1'b1;
            vs_s2       <= 1'b1;
            vs_s3       <= 1'b1;
            state       <= S_IDLE;
            face_select <= FACE_NEUTRAL;
            face_update <= 1'b0;
            pend_face   <= FACE_NEUTRAL;
            blink_cnt   <= '0;
            blk_cnt     <= '0;
            hold_cnt    <= '0;
        end else begin
            vs_s1       <= vga_vs;
            vs_s2       <= vs_s1;
            vs_s3       <= vs_s2;
            state       <= state_next;
            face_select <= face_next;
            face_update <= (face_next != face_select);
            pend_face   <= pend_next;
            blink_cnt   <= blink_cnt_next;
            blk_cnt     <= blk_cnt_next;
            hold_cnt    <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        face_next      = face_select;
        pend_next      = pend_face;
        blink_cnt_next = blink_cnt;
        blk_cnt_next   = blk_cnt;
        hold_cnt_next  = hold_cnt;

        if (manual_en) begin
            // Override wins from any state; a pending event is dropped.
            state_next     = S_MANUAL;
            pend_next      = FACE_NEUTRAL;
            blink_cnt_next = '0;
            blk_cnt_next   = '0;
            hold_cnt_next  = '0;
            if (frame_tick) begin
                face_next = manual_face;
            end
        end else if (accept) begin
            // An accepted event beats a coincident tick, which is dropped.
            // Ready is also offered in MANUAL once the switch is released, and
            // a handshake there is honoured like any other.
            state_next     = S_PENDING;
            pend_next      = evt_face;
            blink_cnt_next = '0;
            blk_cnt_next   = '0;
            hold_cnt_next  = '0;
        end else if (frame_tick) begin
            unique case (state)
                S_IDLE: begin
                    if (blink_cnt == PERIOD_LAST) begin
                        face_next      = FACE_BLINK;
                        blink_cnt_next = '0;
                        state_next     = S_BLINK;
                    end else begin
                        blink_cnt_next = blink_cnt + 1'b1;
                    end
                end
                S_BLINK: begin
                    if (blk_cnt == BLINK_LAST) begin
                        face_next      = FACE_NEUTRAL;
                        blk_cnt_next   = '0;
                        blink_cnt_next = '0;
                        state_next     = S_IDLE;
                    end else begin
                        blk_cnt_next = blk_cnt + 1'b1;
                    end
                end
                S_PENDING: begin
                    face_next = pend_face;
                    if (pend_face == FACE_NEUTRAL) begin
                        blink_cnt_next = '0;
                        state_next     = S_IDLE;
                    end else begin
                        hold_cnt_next = HOLD_LAST;
                        state_next    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        face_next      = FACE_NEUTRAL;
                        blink_cnt_next = '0;
                        state_next     = S_IDLE;
                    end else begin
                        hold_cnt_next = hold_cnt - 1'b1;
                    end
                end
                S_MANUAL: begin
                    face_next      = FACE_NEUTRAL;
                    blink_cnt_next = '0;
                    state_next     = S_IDLE;
                end
                default: begin
                    face_next      = FACE_NEUTRAL;
                    blink_cnt_next = '0;
                    state_next     = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_face_sequencer.sv
// Bench for face_sequencer: directed frame sequences with hand-computed face
// values, then randomized vsync/event/manual/reset traffic, with a frame-level
// behavioural model compared against the outputs every cycle.
module tb_face_sequencer;
    localparam int HOLD_FRAMES  = 3;
    localparam int BLINK_PERIOD = 5;
    localparam int BLINK_FRAMES = 2;

    localparam int M_IDLE  = 0;
    localparam int M_BLINK = 1;
    localparam int M_PEND  = 2;
    localparam int M_HOLD  = 3;
    localparam int M_MAN   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vga_vs = 1'b1;
    logic       manual_en = 1'b0;
    logic [1:0] manual_face = 2'd0;
    logic       evt_valid = 1'b0;
    logic [1:0] evt_face = 2'd0;
    logic       evt_ready;
    logic [1:0] face_select;
    logic       face_update;
    logic       busy;

    face_sequencer #(
        .HOLD_FRAMES (HOLD_FRAMES),
        .BLINK_PERIOD(BLINK_PERIOD),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_vs     (vga_vs),
        .manual_en  (manual_en),
        .manual_face(manual_face),
        .evt_valid  (evt_valid),
        .evt_face   (evt_face),
        .evt_ready  (evt_ready),
        .face_select(face_select),
        .face_update(face_update),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int upd_total = 0;

    // Frame-level model: what is on screen, how many frames remain in the
    // current blink/hold, how many idle frames have elapsed.
    int m_mode = M_IDLE;
    int m_face = 0;
    int m_upd = 0;
    int m_idle_frames = 0;
    int m_blink_left = 0;
    int m_hold_left = 0;
    int m_pend = 0;
    // vsync samples taken at the last three clock edges (newest first)
    bit h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        bit tick;
        bit ready;
        int old_face;
        if (reset) begin
            m_mode = M_IDLE; m_face = 0; m_upd = 0; m_idle_frames = 0;
            m_blink_left = 0; m_hold_left = 0; m_pend = 0;
            h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
            return;
        end
        // A falling edge first sampled two edges ago acts on this edge.
        tick = h3 && !h2;
        h3 = h2; h2 = h1; h1 = vga_vs;
        ready = !manual_en && (m_mode != M_PEND);
        old_face = m_face;
        if (manual_en) begin
            m_mode = M_MAN;
            if (tick) m_face = manual_face;
        end else if (evt_valid && ready) begin
            m_mode = M_PEND;
            m_pend = evt_face;
        end else if (tick) begin
            case (m_mode)
                M_IDLE: begin
                    m_idle_frames++;
                    if (m_idle_frames == BLINK_PERIOD) begin
                        m_face = 3; m_blink_left = BLINK_FRAMES; m_mode = M_BLINK;
                    end
                end
                M_BLINK: begin
                    m_blink_left--;
                    if (m_blink_left == 0) begin
                        m_face = 0; m_idle_frames = 0; m_mode = M_IDLE;
                    end
                end
                M_PEND: begin
                    m_face = m_pend;
                    if (m_pend == 0) begin
                        m_idle_frames = 0; m_mode = M_IDLE;
                    end else begin
                        m_hold_left = HOLD_FRAMES; m_mode = M_HOLD;
                    end
                end
                M_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_face = 0; m_idle_frames = 0; m_mode = M_IDLE;
                    end
                end
                default: begin
                    m_face = 0; m_idle_frames = 0; m_mode = M_IDLE;
                end
            endcase
        end
        m_upd = (m_face != old_face) ? 1 : 0;
    endtask

    // One clock: advance the model on the edge, compare just after it, and
    // return at the following falling clock edge where inputs are driven.
    task automatic tick_cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("face_select", int'(face_select), m_face);
        chk("face_update", int'(face_update), m_upd);
        chk("busy", int'(busy), (m_mode == M_PEND || m_mode == M_HOLD) ? 1 : 0);
        chk("evt_ready", int'(evt_ready), (!reset && !manual_en && m_mode != M_PEND) ? 1 : 0);
        if (face_update) upd_total++;
        @(negedge clk);
    endtask

    task automatic frame();
        vga_vs = 1'b0;
        repeat (3) tick_cycle();
        vga_vs = 1'b1;
        repeat (17) tick_cycle();
    endtask

    task automatic evt(input logic [1:0] f);
        evt_valid = 1'b1;
        evt_face = f;
        tick_cycle();
        evt_valid = 1'b0;
    endtask

    initial begin
        int base;
        int ph;
        int period;
        int low_len;

        repeat (3) tick_cycle();
        reset = 1'b0;
        #1;
        chk("rst_face", int'(face_select), 0);
        chk("rst_update", int'(face_update), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(evt_ready), 1);

        // Idle blink: blink face at tick 5, neutral at 7, blink again at 12.
        base = upd_total;
        for (int i = 1; i <= 12; i++) begin
            frame();
            if (i == 4)  chk("idle_t4", int'(face_select), 0);
            if (i == 5)  chk("idle_t5", int'(face_select), 3);
            if (i == 6)  chk("idle_t6", int'(face_select), 3);
            if (i == 7)  chk("idle_t7", int'(face_select), 0);
            if (i == 11) chk("idle_t11", int'(face_select), 0);
            if (i == 12) chk("idle_t12", int'(face_select), 3);
        end
        chk("idle_pulses", upd_total - base, 3);
        frame();
        frame();
        chk("blink_end", int'(face_select), 0);

        // Event face 2 from IDLE, held for three frames.
        base = upd_total;
        evt_valid = 1'b1;
        evt_face = 2'd2;
        #1;
        chk("evt_ready_idle", int'(evt_ready), 1);
        tick_cycle();
        evt_valid = 1'b0;
        chk("evt_busy", int'(busy), 1);
        chk("evt_pend_face", int'(face_select), 0);
        for (int i = 1; i <= 4; i++) begin
            frame();
            chk("evt_hold", int'(face_select), (i <= 3) ? 2 : 0);
        end
        chk("evt_pulses", upd_total - base, 2);
        chk("evt_done_busy", int'(busy), 0);

        // Event coincident with the tick: the tick is ignored.
        vga_vs = 1'b0;
        tick_cycle();
        tick_cycle();
        evt_valid = 1'b1;
        evt_face = 2'd2;
        tick_cycle();
        evt_valid = 1'b0;
        vga_vs = 1'b1;
        repeat (17) tick_cycle();
        chk("coinc_face", int'(face_select), 0);
        chk("coinc_busy", int'(busy), 1);
        evt_valid = 1'b1;
        evt_face = 2'd1;
        #1;
        chk("pend_ready", int'(evt_ready), 0);
        tick_cycle();
        evt_valid = 1'b0;
        frame();
        chk("coinc_apply", int'(face_select), 2);

        // Manual override while holding.
        manual_en = 1'b1;
        manual_face = 2'd1;
        #1;
        chk("man_ready", int'(evt_ready), 0);
        frame();
        chk("man_face1", int'(face_select), 1);
        chk("man_busy", int'(busy), 0);
        manual_face = 2'd3;
        frame();
        chk("man_face3", int'(face_select), 3);
        manual_en = 1'b0;
        frame();
        chk("man_release", int'(face_select), 0);

        // Same face re-requested during HOLD restarts the hold silently.
        evt(2'd1);
        frame();
        chk("restart_a", int'(face_select), 1);
        frame();
        evt(2'd1);
        base = upd_total;
        frame();
        chk("restart_nopulse", upd_total - base, 0);
        for (int i = 1; i <= 3; i++) begin
            frame();
            chk("restart_hold", int'(face_select), (i <= 2) ? 1 : 0);
        end
        chk("restart_pulses", upd_total - base, 1);

        // Reset while an event is pending discards it.
        evt(2'd2);
        reset = 1'b1;
        tick_cycle();
        reset = 1'b0;
        base = upd_total;
        chk("rstpend_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            frame();
            chk("rstpend_face", int'(face_select), 0);
        end
        chk("rstpend_pulses", upd_total - base, 0);

        // Randomized traffic against the model.
        ph = 0;
        period = 20;
        low_len = 2;
        for (int c = 0; c < 4000; c++) begin
            vga_vs = (ph < low_len) ? 1'b0 : 1'b1;
            ph++;
            if (ph == period) begin
                ph = 0;
                period = int'($urandom_range(6, 30));
                low_len = int'($urandom_range(1, 4));
            end
            evt_valid = ($urandom_range(0, 9) == 0);
            evt_face = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) manual_en = ~manual_en;
            if ($urandom_range(0, 19) == 0) manual_face = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 599) == 0);
            tick_cycle();
        end
        reset = 1'b0;
        evt_valid = 1'b0;
        manual_en = 1'b0;
        repeat (4) tick_cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
